// File: rtl/cpc_bus_sequencer.sv
// cpc_bus_sequencer: four-slot RAM arbiter (VID0, VID1, CPU, IDLE) driven by a 4 MHz phase counter,
// with CPU wait-state generation and video word assembly.
module cpc_bus_sequencer #(
    parameter logic [22:0] VID_BASE = 23'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_4p,
    input  logic        no_wait,
    input  logic        cpu_mreq,
    input  logic        cpu_iorq,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        wait_n,
    output logic        cyc1mhz,
    input  logic [14:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_strobe,
    output logic [22:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    output logic        ram_req,
    input  logic        ram_ack,
    input  logic [7:0]  ram_din
);
    typedef enum logic [1:0] {VID0, VID1, CPU, IDLE} state_t;
    state_t      state;
    logic [1:0]  phase, nphase;
    logic        act, act_d, rise, fall;
    logic        pend, issued, io, vid0_ok, wait_q;
    assign nphase  = phase + 2'd1;
    assign act     = cpu_mreq | cpu_iorq;
    assign rise    = act & ~act_d;
    assign fall    = ~act & act_d;
    assign cyc1mhz = (phase == 2'd3);
    assign wait_n  = wait_q | no_wait;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase      <= 2'd0;
            state      <= IDLE;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            vid_strobe <= 1'b0;
            wait_q     <= 1'b1;
            cpu_din    <= 8'd0;
            vid_data   <= 16'd0;
            ram_addr   <= 23'd0;
            ram_dout   <= 8'd0;
            pend       <= 1'b0;
            issued     <= 1'b0;
            io         <= 1'b0;
            vid0_ok    <= 1'b0;
            // an access still held across reset must not look like a new one
            act_d      <= act;
        end else begin
            act_d      <= act;
            vid_strobe <= 1'b0;
            wait_q     <= ~pend;
            if (rise) begin
                pend   <= 1'b1;
                io     <= ~cpu_mreq;
                issued <= 1'b0;
            end
            if (fall && pend && !issued)
                pend <= 1'b0;
            if (ram_req && ram_ack) begin
                ram_req <= 1'b0;
                ram_we  <= 1'b0;
                if (state == VID0) begin
                    vid_data[7:0] <= ram_din;
                    vid0_ok       <= 1'b1;
                end else if (state == VID1) begin
                    vid_data[15:8] <= ram_din;
                    vid_strobe     <= vid0_ok;
                    vid0_ok        <= 1'b0;
                end else if (state == CPU) begin
                    if (!ram_we)
                        cpu_din <= ram_din;
                    pend   <= 1'b0;
                    issued <= 1'b0;
                end
            end
            // ce_4p pulses arriving while a RAM cycle is open are simply lost
            if (ce_4p && !ram_req) begin
                phase <= nphase;
                state <= state_t'(nphase);
                if (!nphase[1]) begin
                    ram_req  <= 1'b1;
                    ram_we   <= 1'b0;
                    ram_addr <= VID_BASE + {7'd0, vid_addr, nphase[0]};
                end else if (!nphase[0]) begin
                    if (pend && !issued && !fall) begin
                        issued <= 1'b1;
                        if (!io) begin
                            ram_req  <= 1'b1;
                            ram_addr <= cpu_addr;
                            ram_we   <= cpu_wr;
                            ram_dout <= cpu_dout;
                        end
                    end
                end else if (issued && io) begin
                    pend   <= 1'b0;
                    issued <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpc_bus_sequencer.sv
// tb_cpc_bus_sequencer: scoreboard bench with a RAM responder model for cpc_bus_sequencer.
module tb_cpc_bus_sequencer;
    localparam logic [22:0] VB = 23'h100000;
    logic        clk = 0, reset_n = 0, ce_4p = 0, no_wait = 0;
    logic        cpu_mreq = 0, cpu_iorq = 0, cpu_wr = 0;
    logic [22:0] cpu_addr = 0;
    logic [7:0]  cpu_dout = 0, cpu_din;
    logic        wait_n, cyc1mhz, vid_strobe, ram_we, ram_req;
    logic [14:0] vid_addr = 0;
    logic [15:0] vid_data;
    logic [22:0] ram_addr;
    logic [7:0]  ram_dout, ram_din = 0;
    logic        ram_ack = 0;
    int          n_chk = 0, n_fail = 0, n_strobe = 0, n_cpureq = 0;
    int          ack_delay = 0, rcnt = 0, ce_cnt = 0;
    bit          ce_en = 0, ack_en = 1, force_ack = 0, req_d = 0;
    logic [7:0]  mem [logic [22:0]];
    logic [15:0] vid_q [$];
    logic [7:0]  cpu_q [$];

    cpc_bus_sequencer #(.VID_BASE(VB)) dut (
        .clk(clk), .reset_n(reset_n), .ce_4p(ce_4p), .no_wait(no_wait),
        .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .wait_n(wait_n), .cyc1mhz(cyc1mhz), .vid_addr(vid_addr),
        .vid_data(vid_data), .vid_strobe(vid_strobe), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .ram_we(ram_we), .ram_req(ram_req),
        .ram_ack(ram_ack), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [22:0] a);
        return mem.exists(a) ? mem[a] : (a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    function automatic logic [15:0] vword(input logic [14:0] a);
        logic [22:0] b;
        b = VB + {7'd0, a, 1'b0};
        return {rd(b + 23'd1), rd(b)};
    endfunction

    // 4 MHz enable: one pulse every 4 clk
    initial forever begin
        @(posedge clk); #1;
        ce_cnt++;
        ce_4p = ce_en && (ce_cnt % 4 == 0);
    end

    // RAM model: acks ack_delay clk after seeing a request, or a forced pulse when disabled
    initial begin
        mem[23'h012345] = 8'hA5;
        forever begin
            @(posedge clk); #1;
            if (!ack_en) begin
                ram_ack = force_ack;
                ram_din = 8'hFF;
                rcnt = 0;
            end else if (ram_ack) ram_ack = 0;
            else if (ram_req) begin
                if (rcnt >= ack_delay) begin
                    ram_ack = 1;
                    ram_din = rd(ram_addr);
                    if (ram_we) mem[ram_addr] = ram_dout;
                    rcnt = 0;
                end else rcnt++;
            end
        end
    end

    // video scoreboard and CPU-request monitor
    initial begin
        vid_addr = 15'h0123;
        vid_q.push_back(vword(vid_addr));
        forever begin
            @(negedge clk);
            if (vid_strobe) begin
                n_strobe++;
                check("vid_q_size", vid_q.size(), 1);
                if (vid_q.size() > 0) check("vid_data", vid_data, vid_q.pop_front());
                vid_addr = vid_addr + 15'h0111;
                vid_q.push_back(vword(vid_addr));
            end
            if (ram_req && !req_d && (ram_addr < VB || ram_addr >= VB + 23'h8000)) n_cpureq++;
            req_d = ram_req;
        end
    end

    task automatic wait_ce;
        do @(posedge clk); while (!ce_4p);
    endtask

    task automatic to_phase(input int p);
        for (int i = 0; i < 8; i++) begin
            wait_ce;
            @(negedge clk);
            if (cyc1mhz) break;
        end
        check("sync_phase3", cyc1mhz, 1);
        repeat ((p + 1) % 4) wait_ce;
        @(negedge clk);
    endtask

    task automatic wait_req(input logic [22:0] a);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ram_req && ram_addr == a) break;
        end
        check("req_seen", {ram_req, ram_addr}, {1'b1, a});
    endtask

    task automatic wait_ready;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (wait_n) break;
        end
        check("wait_n_release", wait_n, 1);
    endtask

    initial begin
        int s0, hi, nce, dropped, lows, r0;
        bit found;
        repeat (3) @(negedge clk);
        check("rst_ram_req", ram_req, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_vid_strobe", vid_strobe, 0);
        check("rst_wait_n", wait_n, 1);
        check("rst_cpu_din", cpu_din, 0);
        check("rst_vid_data", vid_data, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_dout", ram_dout, 0);
        check("rst_cyc1mhz", cyc1mhz, 0);
        reset_n = 1;
        ce_en = 1;
        wait_ce;
        @(negedge clk);
        check("first_ce_vid1", {ram_req, ram_addr}, {1'b1, VB + {7'd0, vid_addr, 1'b1}});
        repeat (6) @(negedge clk);
        check("no_early_strobe", n_strobe, 0);

        to_phase(3);
        s0 = n_strobe;
        hi = 0;
        repeat (16) begin
            wait_ce;
            @(negedge clk);
            hi += int'(cyc1mhz);
        end
        check("cyc1mhz_rate", hi, 4);
        check("strobe_rate", n_strobe - s0, 4);

        to_phase(0);
        cpu_addr = 23'h012345; cpu_wr = 0; cpu_mreq = 1;
        cpu_q.push_back(8'hA5);
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rd_wait_low", wait_n, 0);
        wait_req(23'h012345);
        check("rd_we", ram_we, 0);
        wait_ready;
        check("rd_cpu_din", cpu_din, cpu_q.pop_front());
        cpu_mreq = 0;

        to_phase(2);
        cpu_addr = 23'h000777; cpu_dout = 8'h3C; cpu_wr = 1; cpu_mreq = 1;
        nce = 0; found = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (ce_4p) nce++;
            @(negedge clk);
            if (ram_req && ram_we) begin found = 1; break; end
        end
        check("wr_found", found, 1);
        check("wr_ce_count", nce, 4);
        check("wr_dout", ram_dout, 8'h3C);
        check("wr_addr", ram_addr, 23'h000777);
        wait_ready;
        cpu_mreq = 0; cpu_wr = 0;
        check("wr_mem", rd(23'h000777), 8'h3C);

        to_phase(3);
        ack_delay = 10;
        wait_ce;
        @(negedge clk);
        check("vid0_req", {ram_req, ram_addr}, {1'b1, VB + {7'd0, vid_addr, 1'b0}});
        dropped = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (ce_4p && ram_req) dropped++;
            @(negedge clk);
            if (!ram_req) break;
        end
        ack_delay = 0;
        check("hold_req_end", ram_req, 0);
        check("hold_dropped_ce", dropped >= 2, 1);
        wait_ce;
        @(negedge clk);
        check("vid1_after_hold", {ram_req, ram_addr}, {1'b1, VB + {7'd0, vid_addr, 1'b1}});

        no_wait = 1;
        r0 = n_cpureq;
        to_phase(0);
        cpu_iorq = 1;
        lows = 0;
        repeat (24) begin
            @(negedge clk);
            if (!wait_n) lows++;
        end
        check("io_nowait_wait_n", lows, 0);
        cpu_iorq = 0;
        no_wait = 0;
        check("io_no_req", n_cpureq - r0, 0);
        to_phase(0);
        cpu_iorq = 1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("io_wait_low", wait_n, 0);
        wait_ready;
        check("io_no_req2", n_cpureq - r0, 0);
        cpu_iorq = 0;

        to_phase(0);
        r0 = n_cpureq;
        cpu_addr = 23'h000555; cpu_wr = 0; cpu_mreq = 1;
        repeat (3) @(negedge clk);
        check("cancel_wait_low", wait_n, 0);
        cpu_mreq = 0;
        repeat (2) @(negedge clk);
        check("cancel_wait_high", wait_n, 1);
        repeat (32) @(negedge clk);
        check("cancel_no_req", n_cpureq - r0, 0);

        to_phase(1);
        repeat (2) @(negedge clk);
        ack_en = 0;
        cpu_addr = 23'h000999; cpu_wr = 0; cpu_mreq = 1;
        wait_req(23'h000999);
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        check("rst_req_drop", ram_req, 0);
        check("rst_wait_high", wait_n, 1);
        force_ack = 1;
        @(negedge clk);
        force_ack = 0;
        repeat (2) @(negedge clk);
        check("late_ack_cpu_din", cpu_din, 0);
        check("rst_no_repend", wait_n, 1);
        ack_en = 1;
        cpu_mreq = 0;

        repeat (80) @(negedge clk);
        check("cpu_q_empty", cpu_q.size(), 0);
        check("strobe_total", n_strobe > 10, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
